ascon_decrypt_fsm: RTL and testbench
====================================

# ascon_decrypt_fsm

Sequencer for the ASCON-128 decryption direction. It drives one `ascon` core, configured in decrypt mode, through the full flow: initialisation, one associated-data block, 23 ciphertext blocks (the last one partial, absorbed with finalisation), and tag generation. It buffers the recovered plaintext and compares the computed tag with the received tag. Plaintext is released only when authentication passes. It is the receive-side counterpart of the encryption sequencer and sits between the link/data interface and the `ascon` core.

## Interface
Parameters:
- MSG_BITS, 1448, message length in bits; 22 full 64-bit blocks plus one 40-bit final block
- N_BLOCKS, 23, total message blocks; fixed by MSG_BITS

Ports:
- clock_i  in  1  clock; all state changes on the rising edge
- reset_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start request; sampled in IDLE only
- cipher_i  in  1448  received ciphertext; block k = bits [64k+63:64k]; must be stable from start to done_o
- tag_i  in  128  received tag; latched on start acceptance
- key_i  in  128  key, passed to core
- nonce_i  in  128  nonce, passed to core
- da_i  in  64  associated-data block; must be stable from start to done_o
- init_o, associate_data_o, finalisation_o, decrypt_o  out  1  core control
- data_o  out  64  core data
- data_valid_o  out  1  core data strobe
- end_initialisation_i, end_associate_i, cipher_valid_i, end_tag_i  in  1  core status
- cipher_core_i  in  64  core output; plaintext in decrypt mode
- tag_core_i  in  128  computed tag
- plain_o  out  1448  released plaintext
- busy_o  out  1  high from start acceptance until done_o
- done_o  out  1  one-cycle pulse at end of run
- auth_ok_o  out  1  tag match result; valid from done_o until the next start

## Operation
- Reset: state IDLE. All outputs 0. Plaintext buffer, tag latch and counter are cleared.
- decrypt_o = 1 whenever busy_o = 1.
- IDLE -> INIT on start_i. At the same time: latch tag_i, clear auth_ok_o and plain_o, clear the buffer.
- INIT: init_o held high. Go to AD on end_initialisation_i.
- AD: associate_data_o = 1. data_o = da_i. data_valid_o pulses for 1 cycle, then goes low until end_associate_i. Then go to MSG; counter = 0.
- MSG: data_o = cipher_i block[counter]. data_valid_o pulses for 1 cycle. Wait in MSG_WAIT for cipher_valid_i.
  - On cipher_valid_i, store cipher_core_i into buffer block[counter] and increment the counter.
  - When counter reaches 22, go to FINAL; otherwise issue the next block.
- FINAL: finalisation_o = 1. data_o = {cipher_i[1447:1408], 8'h80, 16'h0000}. data_valid_o pulses for 1 cycle.
  - On cipher_valid_i, store cipher_core_i[63:24] into buffer [1447:1408].
  - On end_tag_i, capture tag_core_i and go to CHECK.
- CHECK: compare all 128 bits of the captured tag with the latched tag. The compare is a single full-width XOR-reduce with no early exit.
  - On match: plain_o <= buffer and auth_ok_o <= 1.
  - On mismatch: plain_o stays 0, auth_ok_o stays 0, and the buffer is cleared.
- DONE: done_o = 1 for one cycle, busy_o drops, return to IDLE. plain_o and auth_ok_o hold until the next start or reset.
- start_i while busy: ignored.
- Reset at any point: immediate return to IDLE with every output and buffer zeroed; no partial plaintext is ever visible.

## Timing
- All outputs are registered. None depend combinationally on core status inputs.
- data_valid_o is exactly one cycle per block. The next strobe comes no earlier than 1 cycle after the matching cipher_valid_i or end_associate_i.
- Core status inputs arriving in the same cycle as the strobe are accepted (zero-latency core).
- Minimum latency with zero-latency core: start accept to done_o = 2 (INIT) + 2 (AD) + 2 × 22 (MSG) + 2 (FINAL) + 1 (CHECK) + 1 = 52 cycles.
- Counter is 5 bits wide and never exceeds 22; there is no wrap-around.

## Structure
- Package `ascon_pkg`:
  - state enum for this block
  - constants N_FULL_BLOCKS = 22, LAST_BITS = 40, PAD_BYTE = 8'h80, TAG_BITS = 128
- Sub-module: `compteur_Nbits` with N_bits = 5, used as the block counter (en/init controlled by the FSM).
- Plaintext buffer and tag compare live in this module.

## Test plan
- Round trip:
  - Stimulus: key = nonce = 128'h000102030405060708090A0B0C0D0E0F, da_i = 64'h0001020304050607, byte pattern plaintext i mod 256. Encrypt with the encryption sequencer, then feed cipher and tag here.
  - Required: plain_o equals the original, auth_ok_o = 1, done_o once.
- Tag flip: same vectors with tag_i bit 0 inverted -> auth_ok_o = 0, plain_o = 0.
- Ciphertext flip: cipher_i bit 700 inverted -> auth_ok_o = 0, plain_o = 0.
- Reset mid-run: assert reset_i while counter = 10 -> all outputs 0, busy_o = 0 immediately. A following run with the round-trip vectors passes.
- Latency sweep: core stub with 0 and 7 cycle response delays.
  - Required: exactly 24 data_valid_o pulses per run (1 AD + 23 message).
  - Required: 52-cycle minimum latency at zero delay.
- start_i pulsed during the MSG phase -> ignored; exactly one done_o per run.

Source files
------------

// File: rtl/ascon_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ascon_pkg : shared types and constants for the ASCON-128 decrypt sequencer
// rev 1.0
// ----------------------------------------------------------------------------
package ascon_pkg;

  localparam int          N_FULL_BLOCKS = 22;
  localparam int          LAST_BITS     = 40;
  localparam logic [7:0]  PAD_BYTE      = 8'h80;
  localparam int          TAG_BITS      = 128;
  localparam int          BLOCK_BITS    = 64;
  localparam int          CNT_BITS      = 5;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_INIT       = 4'd1,
    S_AD         = 4'd2,
    S_AD_WAIT    = 4'd3,
    S_MSG        = 4'd4,
    S_MSG_WAIT   = 4'd5,
    S_FINAL      = 4'd6,
    S_FINAL_WAIT = 4'd7,
    S_CHECK      = 4'd8,
    S_DONE       = 4'd9
  } dec_state_e;

endpackage

`default_nettype wire

// File: rtl/compteur_Nbits.sv
`default_nettype none
// ----------------------------------------------------------------------------
// compteur_Nbits : N-bit up counter with synchronous clear and enable
// rev 1.0
// ----------------------------------------------------------------------------
module compteur_Nbits #(
  parameter int N_BITS = 5
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              init_i,
  input  logic              en_i,
  output logic [N_BITS-1:0] count_o
);

  logic [N_BITS-1:0] count_q;
  logic [N_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (init_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ascon_decrypt_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ascon_decrypt_fsm : ASCON-128 decrypt sequencer, plaintext gated by tag check
// rev 1.0
// ----------------------------------------------------------------------------
module ascon_decrypt_fsm
  import ascon_pkg::*;
#(
  parameter int MSG_BITS = 1448,
  parameter int N_BLOCKS = 23
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [MSG_BITS-1:0]   cipher_i,
  input  logic [TAG_BITS-1:0]   tag_i,
  input  logic [127:0]          key_i,
  input  logic [127:0]          nonce_i,
  input  logic [63:0]           da_i,
  output logic                  init_o,
  output logic                  associate_data_o,
  output logic                  finalisation_o,
  output logic                  decrypt_o,
  output logic [63:0]           data_o,
  output logic                  data_valid_o,
  input  logic                  end_initialisation_i,
  input  logic                  end_associate_i,
  input  logic                  cipher_valid_i,
  input  logic                  end_tag_i,
  input  logic [63:0]           cipher_core_i,
  input  logic [TAG_BITS-1:0]   tag_core_i,
  output logic [MSG_BITS-1:0]   plain_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  auth_ok_o
);

  localparam int                  FINAL_LSB = N_FULL_BLOCKS * BLOCK_BITS;
  localparam logic [CNT_BITS-1:0] LAST_IDX  = CNT_BITS'(N_BLOCKS - 2);

  dec_state_e            state_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [MSG_BITS-1:0]   buf_q;
  logic [MSG_BITS-1:0]   plain_q;
  logic [TAG_BITS-1:0]   tag_rx_q;
  logic [TAG_BITS-1:0]   tag_calc_q;
  logic [63:0]           data_q;
  logic                  init_q, assoc_q, final_q, dec_q, dv_q, busy_q, done_q, auth_q;
  logic                  cnt_init, cnt_en, tag_match;
  logic                  unused_inputs;

  // Key, nonce and the padding bits of the last core word are consumed by the core, not here.
  assign unused_inputs = ^{key_i, nonce_i, cipher_core_i[23:0]};

  assign cnt_init  = ((state_q == S_IDLE) && start_i) || ((state_q == S_AD_WAIT) && end_associate_i);
  assign cnt_en    = (state_q == S_MSG_WAIT) && cipher_valid_i;
  assign tag_match = ~|(tag_calc_q ^ tag_rx_q);

  compteur_Nbits #(.N_BITS(CNT_BITS)) u_blk_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .init_i  (cnt_init),
    .en_i    (cnt_en),
    .count_o (cnt_q)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      plain_q    <= '0;
      tag_rx_q   <= '0;
      tag_calc_q <= '0;
      data_q     <= '0;
      init_q     <= 1'b0;
      assoc_q    <= 1'b0;
      final_q    <= 1'b0;
      dec_q      <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      auth_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            tag_rx_q <= tag_i;
            auth_q   <= 1'b0;
            plain_q  <= '0;
            buf_q    <= '0;
            busy_q   <= 1'b1;
            dec_q    <= 1'b1;
            init_q   <= 1'b1;
            state_q  <= S_INIT;
          end
        end
        S_INIT: begin
          if (end_initialisation_i) begin
            init_q  <= 1'b0;
            assoc_q <= 1'b1;
            state_q <= S_AD;
          end
        end
        S_AD: begin
          data_q  <= da_i;
          dv_q    <= 1'b1;
          state_q <= S_AD_WAIT;
        end
        S_AD_WAIT: begin
          dv_q <= 1'b0;
          if (end_associate_i) begin
            assoc_q <= 1'b0;
            state_q <= S_MSG;
          end
        end
        S_MSG: begin
          data_q  <= cipher_i[{cnt_q, 6'b0} +: BLOCK_BITS];
          dv_q    <= 1'b1;
          state_q <= S_MSG_WAIT;
        end
        S_MSG_WAIT: begin
          dv_q <= 1'b0;
          if (cipher_valid_i) begin
            buf_q[{cnt_q, 6'b0} +: BLOCK_BITS] <= cipher_core_i;
            if (cnt_q == LAST_IDX) begin
              final_q <= 1'b1;
              state_q <= S_FINAL;
            end else begin
              state_q <= S_MSG;
            end
          end
        end
        S_FINAL: begin
          data_q  <= {cipher_i[FINAL_LSB +: LAST_BITS], PAD_BYTE, 16'h0000};
          dv_q    <= 1'b1;
          state_q <= S_FINAL_WAIT;
        end
        S_FINAL_WAIT: begin
          dv_q <= 1'b0;
          if (cipher_valid_i) begin
            buf_q[FINAL_LSB +: LAST_BITS] <= cipher_core_i[63:24];
          end
          if (end_tag_i) begin
            tag_calc_q <= tag_core_i;
            final_q    <= 1'b0;
            state_q    <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A failed tag wipes the recovered plaintext so it never leaves the block.
          if (tag_match) begin
            plain_q <= buf_q;
            auth_q  <= 1'b1;
          end else begin
            buf_q   <= '0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          dec_q   <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign init_o           = init_q;
  assign associate_data_o = assoc_q;
  assign finalisation_o   = final_q;
  assign decrypt_o        = dec_q;
  assign data_o           = data_q;
  assign data_valid_o     = dv_q;
  assign plain_o          = plain_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign auth_ok_o        = auth_q;

endmodule

`default_nettype wire

// File: tb/tb_ascon_decrypt_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ascon_decrypt_fsm : randomized bench with a behavioural core stub and model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_ascon_decrypt_fsm;

  localparam int K_INIT = 0;
  localparam int K_AD   = 1;
  localparam int K_MSG  = 2;
  localparam int K_FIN  = 3;

  logic           clock_i = 1'b0;
  logic           reset_i = 1'b1;
  logic           start_i = 1'b0;
  logic [1447:0]  cipher_i = '0;
  logic [127:0]   tag_i = '0;
  logic [127:0]   key_i = '0;
  logic [127:0]   nonce_i = '0;
  logic [63:0]    da_i = '0;
  logic           init_o, associate_data_o, finalisation_o, decrypt_o;
  logic [63:0]    data_o;
  logic           data_valid_o;
  logic           end_initialisation_i, end_associate_i, cipher_valid_i, end_tag_i;
  logic [63:0]    cipher_core_i;
  logic [127:0]   tag_core_i;
  logic [1447:0]  plain_o;
  logic           busy_o, done_o, auth_ok_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock_i = ~clock_i;

  ascon_decrypt_fsm #(.MSG_BITS(1448), .N_BLOCKS(23)) dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .start_i              (start_i),
    .cipher_i             (cipher_i),
    .tag_i                (tag_i),
    .key_i                (key_i),
    .nonce_i              (nonce_i),
    .da_i                 (da_i),
    .init_o               (init_o),
    .associate_data_o     (associate_data_o),
    .finalisation_o       (finalisation_o),
    .decrypt_o            (decrypt_o),
    .data_o               (data_o),
    .data_valid_o         (data_valid_o),
    .end_initialisation_i (end_initialisation_i),
    .end_associate_i      (end_associate_i),
    .cipher_valid_i       (cipher_valid_i),
    .end_tag_i            (end_tag_i),
    .cipher_core_i        (cipher_core_i),
    .tag_core_i           (tag_core_i),
    .plain_o              (plain_o),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .auth_ok_o            (auth_ok_o)
  );

  // Toy reversible cipher: keystream per block index, tag is a rotate-xor hash of absorbed words.
  function automatic logic [63:0] ks(input int idx, input logic [127:0] k, input logic [127:0] n);
    return (k[63:0] ^ n[127:64]) ^ (64'h9E3779B97F4A7C15 * 64'(idx + 1));
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] h, input logic [63:0] d);
    return {h[118:0], h[127:119]} ^ {d, d ^ 64'hA5A5_5A5A_0F0F_F0F0};
  endfunction

  function automatic logic [127:0] tag_ref(input logic [1447:0] ct, input logic [63:0] d,
                                           input logic [127:0] k, input logic [127:0] n);
    logic [127:0] hh;
    logic [63:0]  fb;
    hh = mix(k ^ n, d);
    for (int b = 0; b < 22; b++) hh = mix(hh, ct[b*64 +: 64]);
    fb = {ct[1447:1408], 8'h80, 16'h0000};
    hh = mix(hh, fb);
    return hh ^ k;
  endfunction

  // ---------------- core stub with programmable response delay ----------------
  int           dly = 0;
  logic         init_served, pend, init_req, req_now, fire;
  int           pcnt, p_kind, kind_now, r_kind, idx;
  logic [63:0]  p_data, r_data;
  logic [127:0] h;

  always_comb begin
    init_req = init_o && !init_served;
    req_now  = init_req || data_valid_o;
    kind_now = init_req ? K_INIT : associate_data_o ? K_AD : finalisation_o ? K_FIN : K_MSG;
    fire     = 1'b0;
    r_kind   = p_kind;
    r_data   = p_data;
    if (req_now && dly == 0) begin
      fire   = 1'b1;
      r_kind = kind_now;
      r_data = data_o;
    end else if (pend && pcnt == dly) begin
      fire = 1'b1;
    end
    end_initialisation_i = fire && (r_kind == K_INIT);
    end_associate_i      = fire && (r_kind == K_AD);
    cipher_valid_i       = fire && (r_kind == K_MSG || r_kind == K_FIN);
    end_tag_i            = fire && (r_kind == K_FIN);
    cipher_core_i        = cipher_valid_i ? (r_data ^ ks(idx, key_i, nonce_i)) : 64'h0;
    tag_core_i           = end_tag_i ? (mix(h, r_data) ^ key_i) : 128'h0;
  end

  always @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      init_served <= 1'b0;
      pend        <= 1'b0;
      pcnt        <= 0;
      p_kind      <= 0;
      p_data      <= '0;
      h           <= '0;
      idx         <= 0;
    end else begin
      init_served <= init_o ? (init_served | init_req) : 1'b0;
      if (req_now && dly != 0) begin
        pend   <= 1'b1;
        pcnt   <= 1;
        p_kind <= kind_now;
        p_data <= data_o;
      end else if (pend) begin
        if (pcnt == dly) pend <= 1'b0;
        else             pcnt <= pcnt + 1;
      end
      if (fire) begin
        case (r_kind)
          K_INIT:  begin h <= key_i ^ nonce_i; idx <= 0; end
          K_MSG:   begin h <= mix(h, r_data); idx <= idx + 1; end
          default: h <= mix(h, r_data);
        endcase
      end
    end
  end

  // ---------------- monitors ----------------
  int   cyc = 0, dv_total = 0, done_total = 0, cv_total = 0;
  int   bad_dec = 0, bad_dv = 0, bad_busy = 0, done_edge = 0;
  logic dv_prev = 1'b0;

  always @(posedge clock_i) begin
    cyc     <= cyc + 1;
    dv_prev <= data_valid_o;
    if (data_valid_o)                  dv_total <= dv_total + 1;
    if (data_valid_o && dv_prev)       bad_dv   <= bad_dv + 1;
    if (decrypt_o !== busy_o)          bad_dec  <= bad_dec + 1;
    if (cipher_valid_i && !end_tag_i)  cv_total <= cv_total + 1;
    if (done_o) begin
      done_total <= done_total + 1;
      done_edge  <= cyc;
      if (busy_o) bad_busy <= bad_busy + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [1447:0] got, input logic [1447:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_one(input string nm, input logic [127:0] kk, input logic [127:0] nn,
                         input logic [63:0] d, input logic [1447:0] pt, input int tflip,
                         input int cflip, input int delay, input bit pulse_mid, input bit chk_lat);
    logic [1447:0] ct, exp_plain;
    logic [127:0]  tg;
    logic [63:0]   ksl;
    bit            ok_exp, pulsed;
    int            dv0, done0, cv0, s_edge, waited;
    for (int b = 0; b < 22; b++) ct[b*64 +: 64] = pt[b*64 +: 64] ^ ks(b, kk, nn);
    ksl = ks(22, kk, nn);
    ct[1447:1408] = pt[1447:1408] ^ ksl[63:24];
    tg = tag_ref(ct, d, kk, nn);
    ok_exp = (tflip < 0) && (cflip < 0);
    if (tflip >= 0) tg[tflip] = ~tg[tflip];
    if (cflip >= 0) ct[cflip] = ~ct[cflip];
    exp_plain = ok_exp ? pt : '0;

    @(negedge clock_i);
    dly = delay; key_i = kk; nonce_i = nn; da_i = d; cipher_i = ct; tag_i = tg;
    dv0 = dv_total; done0 = done_total; cv0 = cv_total;
    start_i = 1'b1;
    @(posedge clock_i);
    s_edge = cyc;
    @(negedge clock_i);
    start_i = 1'b0;
    waited = 0; pulsed = 1'b0;
    while (done_total == done0 && waited < 3000) begin
      @(negedge clock_i);
      waited++;
      start_i = pulse_mid && !pulsed && (cv_total - cv0 == 5);
      if (start_i) pulsed = 1'b1;
    end
    start_i = 1'b0;
    check_eq({nm, "_timeout"}, waited < 3000, 1'b1);
    if (chk_lat) check_eq({nm, "_latency"}, done_edge - s_edge + 1, 52);
    check_eq({nm, "_auth"}, auth_ok_o, ok_exp);
    check_eq({nm, "_plain"}, plain_o, exp_plain);
    repeat (4) @(negedge clock_i);
    check_eq({nm, "_done_cnt"}, done_total - done0, 1);
    check_eq({nm, "_dv_cnt"}, dv_total - dv0, 24);
    check_eq({nm, "_auth_hold"}, auth_ok_o, ok_exp);
  endtask

  logic [127:0]  fk, rk, rn;
  logic [63:0]   fd, rd;
  logic [1447:0] fpt, rpt;
  int            cv0, w, mode;

  initial begin
    fk = 128'h000102030405060708090A0B0C0D0E0F;
    fd = 64'h0001020304050607;
    for (int i = 0; i < 181; i++) fpt[i*8 +: 8] = 8'(i % 256);

    repeat (3) @(negedge clock_i);
    #1;
    check_eq("rst_ctrl", {init_o, associate_data_o, finalisation_o, decrypt_o, data_valid_o}, 5'b0);
    check_eq("rst_status", {busy_o, done_o, auth_ok_o}, 3'b0);
    check_eq("rst_data", data_o, 64'h0);
    check_eq("rst_plain", plain_o, '0);
    @(negedge clock_i);
    reset_i = 1'b0;

    run_one("roundtrip", fk, fk, fd, fpt, -1, -1, 0, 1'b0, 1'b1);
    run_one("tagflip",   fk, fk, fd, fpt,  0, -1, 0, 1'b0, 1'b0);
    run_one("ctflip",    fk, fk, fd, fpt, -1, 700, 0, 1'b0, 1'b0);

    // reset while the block counter sits at 10
    @(negedge clock_i);
    dly = 0; key_i = fk; nonce_i = fk; da_i = fd;
    cv0 = cv_total; start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    w = 0;
    while (cv_total - cv0 < 10 && w < 1000) begin
      @(negedge clock_i);
      w++;
    end
    check_eq("midrst_reach", w < 1000, 1'b1);
    check_eq("midrst_busy_before", busy_o, 1'b1);
    reset_i = 1'b1;
    #1;
    check_eq("midrst_status", {busy_o, done_o, auth_ok_o, data_valid_o, decrypt_o}, 5'b0);
    check_eq("midrst_plain", plain_o, '0);
    @(negedge clock_i);
    reset_i = 1'b0;
    run_one("after_rst", fk, fk, fd, fpt, -1, -1, 0, 1'b0, 1'b1);

    run_one("delay7", fk, fk, fd, fpt, -1, -1, 7, 1'b0, 1'b0);
    run_one("start_mid", fk, fk, fd, fpt, -1, -1, 0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rn = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom};
      for (int i = 0; i < 45; i++) rpt[i*32 +: 32] = $urandom;
      rpt[1447:1440] = 8'($urandom);
      mode = $urandom_range(0, 2);
      run_one("random", rk, rn, rd, rpt,
              (mode == 1) ? int'($urandom_range(0, 127)) : -1,
              (mode == 2) ? int'($urandom_range(0, 1447)) : -1,
              int'($urandom_range(0, 7)), 1'b0, 1'b0);
    end

    check_eq("decrypt_eq_busy", bad_dec, 0);
    check_eq("dv_single_cycle", bad_dv, 0);
    check_eq("busy_low_at_done", bad_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
